// File: rtl/unidade_acesso_memoria_pkg.sv
`default_nettype none
// ============================================================================
// Module      : unidade_acesso_memoria_pkg
// Description : Shared definitions for the memory access unit: access-size
//               codes, FSM state encoding and the alignment rule.
// Revision    : 1.0 - initial release
// ============================================================================
package unidade_acesso_memoria_pkg;

    // Access size codes (11 is not listed and is handled as a word)
    localparam logic [1:0] c_size_word = 2'b00;
    localparam logic [1:0] c_size_half = 2'b01;
    localparam logic [1:0] c_size_byte = 2'b10;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t c_st_idle = 3'd0;
    localparam state_t c_st_rd1  = 3'd1;
    localparam state_t c_st_rd2  = 3'd2;
    localparam state_t c_st_wr   = 3'd3;
    localparam state_t c_st_done = 3'd4;
    localparam state_t c_st_err  = 3'd5;

    // Halfwords need an even address, words (and code 11) need a 4-byte
    // aligned address; bytes can never be misaligned.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic r;
        case (size)
            c_size_byte: r = 1'b0;
            c_size_half: r = offset[0];
            default:     r = (offset != 2'b00);
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/unidade_acesso_memoria_if.sv
`default_nettype none
// ============================================================================
// Module      : unidade_acesso_memoria_if
// Description : Request and memory-bus signals of the memory access unit.
//               slave  : the access unit (samples request, drives memory).
//               master : the requester / memory model.
//   start, op_write, size, sign_ext, addr, wdata : request
//   mem_rdata                                    : memory read word
//   mem_addr, mem_wdata, mem_we                  : memory write/address side
//   busy, done, misaligned, mdr                  : status and load result
// Revision    : 1.0 - initial release
// ============================================================================
interface unidade_acesso_memoria_if;
    logic        start;
    logic        op_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        misaligned;
    logic [31:0] mdr;

    modport slave (
        input  start, op_write, size, sign_ext, addr, wdata, mem_rdata,
        output mem_addr, mem_wdata, mem_we, busy, done, misaligned, mdr
    );

    modport master (
        output start, op_write, size, sign_ext, addr, wdata, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, busy, done, misaligned, mdr
    );
endinterface
`default_nettype wire

// File: rtl/unidade_acesso_memoria_alinhador_bytes.sv
`default_nettype none
// ============================================================================
// Module      : alinhador_bytes
// Description : Little-endian lane handling. Extracts the addressed byte or
//               halfword of a memory word (sign- or zero-extended) and builds
//               the word to store by replacing only the addressed lane(s).
//   i_word      : word read from memory
//   i_offset    : byte offset addr[1:0]
//   i_size      : access size code
//   i_sign_ext  : 1 = sign-extend sub-word loads
//   i_wdata     : store data (low byte/halfword used for sub-word stores)
//   o_extracted : load result
//   o_merged    : word to write back
// Revision    : 1.0 - initial release
// ============================================================================
module alinhador_bytes
    import unidade_acesso_memoria_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_extracted,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte      = i_word[{i_offset, 3'b000} +: 8];
        w_half      = i_offset[1] ? i_word[31:16] : i_word[15:0];
        o_extracted = i_word;
        o_merged    = i_wdata;
        case (i_size)
            c_size_byte: begin
                o_extracted = {{24{i_sign_ext & w_byte[7]}}, w_byte};
                o_merged    = i_word;
                o_merged[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
            end
            c_size_half: begin
                o_extracted = {{16{i_sign_ext & w_half[15]}}, w_half};
                o_merged    = i_word;
                o_merged[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/unidade_acesso_memoria.sv
`default_nettype none
// ============================================================================
// Module      : unidade_acesso_memoria
// Description : Memory access unit. Performs word/halfword/byte loads and
//               stores against a word-wide memory with one-cycle read latency.
//               Sub-word stores are read-modify-write.
//   clock   : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : request/memory/status signals (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module unidade_acesso_memoria
    import unidade_acesso_memoria_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset_n,
    unidade_acesso_memoria_if.slave   bus
);

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_write;
    logic        r_sext;
    logic [31:0] r_mdr;
    logic [31:0] r_wbuf;

    logic [31:0] w_extracted;
    logic [31:0] w_merged;
    logic        w_req_mis;
    logic        w_req_word;
    logic        w_lat_word;

    // Alignment and size classification act on the live request so the
    // IDLE decision is taken in the sampling cycle itself.
    assign w_req_mis  = is_misaligned(bus.size, bus.addr[1:0]);
    assign w_req_word = (bus.size != c_size_half) && (bus.size != c_size_byte);
    assign w_lat_word = (r_size != c_size_half) && (r_size != c_size_byte);

    alinhador_bytes u_alinhador (
        .i_word      (bus.mem_rdata),
        .i_offset    (r_addr[1:0]),
        .i_size      (r_size),
        .i_sign_ext  (r_sext),
        .i_wdata     (r_wdata),
        .o_extracted (w_extracted),
        .o_merged    (w_merged)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= c_size_word;
            r_write <= 1'b0;
            r_sext  <= 1'b0;
            r_mdr   <= '0;
            r_wbuf  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.start) begin
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_size  <= bus.size;
                        r_write <= bus.op_write;
                        r_sext  <= bus.sign_ext;
                        if (w_req_mis)
                            r_state <= c_st_err;
                        else if (bus.op_write && w_req_word)
                            r_state <= c_st_wr;
                        else
                            r_state <= c_st_rd1;
                    end
                end
                c_st_rd1: r_state <= c_st_rd2;
                c_st_rd2: begin
                    // mem_rdata now holds the word addressed during RD1
                    if (r_write) begin
                        r_wbuf  <= w_merged;
                        r_state <= c_st_wr;
                    end else begin
                        r_mdr   <= w_extracted;
                        r_state <= c_st_done;
                    end
                end
                c_st_wr:   r_state <= c_st_done;
                c_st_done: r_state <= c_st_idle;
                c_st_err:  r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.mem_addr   = {r_addr[31:2], 2'b00};
    assign bus.mem_wdata  = w_lat_word ? r_wdata : r_wbuf;
    assign bus.mem_we     = (r_state == c_st_wr);
    assign bus.busy       = (r_state != c_st_idle);
    assign bus.done       = (r_state == c_st_done) || (r_state == c_st_err);
    assign bus.misaligned = (r_state == c_st_err);
    assign bus.mdr        = r_mdr;

endmodule
`default_nettype wire

// File: tb/tb_unidade_acesso_memoria.sv
`default_nettype none
// ============================================================================
// Module      : tb_unidade_acesso_memoria
// Description : Self-checking bench for unidade_acesso_memoria: word-wide RAM
//               with one-cycle read latency, a latency/result model of the
//               unit checked every cycle, and directed scenarios with
//               hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unidade_acesso_memoria;

    localparam logic [31:0] PRELOAD = 32'h8899AABB;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic preload_req = 1'b1;
    always #5 clock = ~clock;

    unidade_acesso_memoria_if bif ();

    unidade_acesso_memoria dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bif)
    );

    // ---------------- memory ----------------
    logic [31:0] ram [0:255];
    always @(posedge clock) begin
        if (preload_req)
            ram[64] <= PRELOAD;
        else if (bif.mem_we)
            ram[bif.mem_addr[9:2]] <= bif.mem_wdata;
        bif.mem_rdata <= ram[bif.mem_addr[9:2]];
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit [31:0] f_load(bit [31:0] w, bit [31:0] a, bit [1:0] sz, bit sx);
        bit [31:0] v;
        int sh;
        if (sz == 2'b10) begin
            sh = 8 * a[1:0];
            v = (w >> sh) & 32'hFF;
            if (sx && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz == 2'b01) begin
            sh = 16 * a[1];
            v = (w >> sh) & 32'hFFFF;
            if (sx && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic bit [31:0] f_store(bit [31:0] w, bit [31:0] a, bit [1:0] sz, bit [31:0] wd);
        bit [31:0] mask;
        bit [31:0] data;
        int sh;
        if (sz == 2'b10) begin
            sh = 8 * a[1:0];
            mask = 32'hFF << sh;
            data = (wd & 32'hFF) << sh;
        end else if (sz == 2'b01) begin
            sh = 16 * a[1];
            mask = 32'hFFFF << sh;
            data = (wd & 32'hFFFF) << sh;
        end else begin
            return wd;
        end
        return (w & ~mask) | (data & mask);
    endfunction

    function automatic bit f_mis(bit [31:0] a, bit [1:0] sz);
        if (sz == 2'b10) return 1'b0;
        if (sz == 2'b01) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    bit        m_active = 0;
    int        m_cyc = 0;
    int        m_lat = 0;
    bit        m_err = 0;
    bit        m_store = 0;
    bit [31:0] m_addr = 0;
    bit [31:0] m_wdata = 0;
    bit [1:0]  m_size = 0;
    bit        m_sext = 0;
    bit [31:0] m_mdr = 0;
    bit [31:0] mm [0:255];

    // m_cyc is the number of the current cycle counted from the accepting edge
    initial begin
        for (int i = 0; i < 256; i++) mm[i] = 32'h0;
        forever begin
            @(posedge clock or negedge reset_n);
            if (preload_req) mm[64] = PRELOAD;
            if (!reset_n) begin
                m_active = 0;
                m_cyc    = 0;
                m_mdr    = 0;
            end else if (m_active) begin
                m_cyc++;
                if (m_cyc == m_lat && !m_err) begin
                    if (m_store)
                        mm[m_addr[9:2]] = f_store(mm[m_addr[9:2]], m_addr, m_size, m_wdata);
                    else
                        m_mdr = f_load(mm[m_addr[9:2]], m_addr, m_size, m_sext);
                end
                if (m_cyc > m_lat) m_active = 0;
            end else if (bif.start) begin
                m_addr   = bif.addr;
                m_wdata  = bif.wdata;
                m_size   = bif.size;
                m_sext   = bif.sign_ext;
                m_store  = bif.op_write;
                m_err    = f_mis(bif.addr, bif.size);
                if (m_err)                                 m_lat = 1;
                else if (!m_store)                         m_lat = 3;
                else if (m_size == 2'b01 || m_size == 2'b10) m_lat = 4;
                else                                       m_lat = 2;
                m_cyc    = 1;
                m_active = 1;
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        bit e_done, e_we;
        forever begin
            @(posedge clock);
            #1;
            e_done = m_active && (m_cyc == m_lat);
            e_we   = m_active && m_store && !m_err && (m_cyc == m_lat - 1);
            chk("busy",       {31'b0, bif.busy},       {31'b0, m_active});
            chk("done",       {31'b0, bif.done},       {31'b0, e_done});
            chk("misaligned", {31'b0, bif.misaligned}, {31'b0, e_done && m_err});
            chk("mem_we",     {31'b0, bif.mem_we},     {31'b0, e_we});
            chk("mdr",        bif.mdr,                 m_mdr);
            if (m_active && !m_err)
                chk("mem_addr", bif.mem_addr, {m_addr[31:2], 2'b00});
            if (e_we)
                chk("mem_wdata", bif.mem_wdata,
                    f_store(mm[m_addr[9:2]], m_addr, m_size, m_wdata));
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_op(input bit wr, input bit [1:0] sz, input bit sx,
                         input bit [31:0] a, input bit [31:0] wd, input bit hold,
                         output int done_cyc, output int we_cnt, output int we_cyc,
                         output bit mis);
        int cyc;
        bit seen;
        done_cyc = -1; we_cnt = 0; we_cyc = -1; mis = 0; seen = 0;
        @(negedge clock);
        bif.start = 1'b1; bif.op_write = wr; bif.size = sz;
        bif.sign_ext = sx; bif.addr = a; bif.wdata = wd;
        @(posedge clock); #1;
        cyc = 1;
        while (!seen && cyc <= 20) begin
            if (bif.mem_we) begin we_cnt++; we_cyc = cyc; end
            if (bif.done) begin
                seen = 1; done_cyc = cyc; mis = bif.misaligned;
            end else begin
                @(negedge clock);
                if (!hold) bif.start = 1'b0;
                @(posedge clock); #1;
                cyc++;
            end
        end
        @(negedge clock);
        bif.start = 1'b0;
        if (!seen) chk("op_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct { bit [1:0] sz; bit sx; bit [31:0] a; bit [31:0] exp; } ld_t;

    initial begin
        int dc, wc, wy, cnt_we, cnt_done;
        bit mis;
        ld_t lds [4];
        lds[0] = '{2'b10, 1'b1, 32'h103, 32'hFFFFFF88};
        lds[1] = '{2'b10, 1'b0, 32'h103, 32'h00000088};
        lds[2] = '{2'b01, 1'b1, 32'h102, 32'hFFFF8899};
        lds[3] = '{2'b10, 1'b1, 32'h100, 32'hFFFFFFBB};

        bif.start = 0; bif.op_write = 0; bif.size = 0; bif.sign_ext = 0;
        bif.addr = 0; bif.wdata = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy",      {31'b0, bif.busy},       32'd0);
        chk("rst_done",      {31'b0, bif.done},       32'd0);
        chk("rst_mis",       {31'b0, bif.misaligned}, 32'd0);
        chk("rst_we",        {31'b0, bif.mem_we},     32'd0);
        chk("rst_mdr",       bif.mdr,                 32'd0);
        chk("rst_mem_addr",  bif.mem_addr,            32'd0);
        chk("rst_mem_wdata", bif.mem_wdata,           32'd0);
        @(negedge clock);
        preload_req = 1'b0;
        reset_n = 1'b1;

        // Word load
        do_op(0, 2'b00, 0, 32'h100, 0, 0, dc, wc, wy, mis);
        chk("wload_mdr", bif.mdr, 32'h8899AABB);
        chk("wload_done_cyc", dc, 32'd3);
        chk("wload_we_cnt", wc, 32'd0);

        // Sub-word loads
        for (int i = 0; i < 4; i++) begin
            do_op(0, lds[i].sz, lds[i].sx, lds[i].a, 0, 0, dc, wc, wy, mis);
            chk("subload_mdr", bif.mdr, lds[i].exp);
            chk("subload_done_cyc", dc, 32'd3);
        end

        // Byte store
        do_op(1, 2'b10, 0, 32'h101, 32'h123456CC, 0, dc, wc, wy, mis);
        chk("bstore_done_cyc", dc, 32'd4);
        chk("bstore_we_cnt", wc, 32'd1);
        chk("bstore_we_cyc", wy, 32'd3);
        chk("bstore_mem", ram[64], 32'h8899CCBB);
        chk("bstore_mdr_kept", bif.mdr, 32'hFFFFFFBB);

        // Restore preload
        @(negedge clock); preload_req = 1'b1;
        @(negedge clock); preload_req = 1'b0;
        chk("preload_mem", ram[64], PRELOAD);

        // Misaligned word load
        do_op(0, 2'b00, 0, 32'h102, 0, 0, dc, wc, wy, mis);
        chk("mis_done_cyc", dc, 32'd1);
        chk("mis_flag", {31'b0, mis}, 32'd1);
        chk("mis_we_cnt", wc, 32'd0);
        chk("mis_mdr_kept", bif.mdr, 32'hFFFFFFBB);

        // Halfword store aborted by reset during RD2
        @(negedge clock);
        bif.start = 1; bif.op_write = 1; bif.size = 2'b01; bif.sign_ext = 0;
        bif.addr = 32'h100; bif.wdata = 32'h55557777;
        @(posedge clock); #1;
        @(negedge clock); bif.start = 0;
        @(posedge clock); #1;
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy",      {31'b0, bif.busy},   32'd0);
        chk("abort_done",      {31'b0, bif.done},   32'd0);
        chk("abort_we",        {31'b0, bif.mem_we}, 32'd0);
        chk("abort_mdr",       bif.mdr,             32'd0);
        chk("abort_mem_addr",  bif.mem_addr,        32'd0);
        chk("abort_mem_wdata", bif.mem_wdata,       32'd0);
        @(negedge clock); reset_n = 1'b1;
        cnt_we = 0; cnt_done = 0;
        repeat (8) begin
            @(posedge clock); #1;
            if (bif.mem_we) cnt_we++;
            if (bif.done) cnt_done++;
        end
        chk("abort_we_after", cnt_we, 32'd0);
        chk("abort_done_after", cnt_done, 32'd0);
        chk("abort_mem", ram[64], PRELOAD);

        // Word store with start held high
        do_op(1, 2'b00, 0, 32'h104, 32'hDEADBEEF, 1, dc, wc, wy, mis);
        chk("hold_we_cnt", wc, 32'd1);
        chk("hold_done_cyc", dc, 32'd2);
        chk("hold_mem", ram[65], 32'hDEADBEEF);

        // Load accepted in the cycle right after done
        do_op(0, 2'b00, 0, 32'h104, 0, 0, dc, wc, wy, mis);
        chk("b2b_mdr", bif.mdr, 32'hDEADBEEF);
        chk("b2b_done_cyc", dc, 32'd3);

        // Halfword store to the upper lane, then read it back
        do_op(1, 2'b01, 0, 32'h102, 32'hABCD1234, 0, dc, wc, wy, mis);
        chk("hstore_mem", ram[64], 32'h1234AABB);
        do_op(0, 2'b01, 1, 32'h102, 0, 0, dc, wc, wy, mis);
        chk("hload_mdr", bif.mdr, 32'h00001234);

        // Size code 11 behaves as a word
        do_op(0, 2'b11, 1, 32'h100, 0, 0, dc, wc, wy, mis);
        chk("size11_mdr", bif.mdr, 32'h1234AABB);

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
